// File: rtl/viterbi_ctrl_if.sv
// viterbi_ctrl_if: symbol stream and decoder-datapath control bundle for viterbi_ctrl.
// The abort input exists only when VITERBI_CTRL_ABORT_EN is defined.
interface viterbi_ctrl_if #(
    parameter int DATA_WIDTH = 2,
    parameter int FRAME_LEN  = 16
);
    localparam int CNT_W = $clog2(FRAME_LEN);
    logic                  start;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] bmu_rx_data;
    logic                  pm_clear;
    logic                  acs_en;
    logic [CNT_W-1:0]      sp_wr_addr;
    logic                  tb_en;
    logic [CNT_W-1:0]      tb_addr;
    logic                  busy;
    logic                  done;
`ifdef VITERBI_CTRL_ABORT_EN
    logic                  abort;
    modport slave (
        input  start, in_valid, in_data, abort,
        output in_ready, bmu_rx_data, pm_clear, acs_en, sp_wr_addr, tb_en, tb_addr, busy, done
    );
    modport master (
        output start, in_valid, in_data, abort,
        input  in_ready, bmu_rx_data, pm_clear, acs_en, sp_wr_addr, tb_en, tb_addr, busy, done
    );
`else
    modport slave (
        input  start, in_valid, in_data,
        output in_ready, bmu_rx_data, pm_clear, acs_en, sp_wr_addr, tb_en, tb_addr, busy, done
    );
    modport master (
        output start, in_valid, in_data,
        input  in_ready, bmu_rx_data, pm_clear, acs_en, sp_wr_addr, tb_en, tb_addr, busy, done
    );
`endif
endinterface

// File: rtl/viterbi_ctrl.sv
// viterbi_ctrl: frame sequencer for the Viterbi datapath (clear, ACS stages, traceback, done).
// Optional abort input enabled by defining VITERBI_CTRL_ABORT_EN.
module viterbi_ctrl #(
    parameter int DATA_WIDTH = 2,
    parameter int FRAME_LEN  = 16
) (
    input logic          clk,
    input logic          rst_n,
    viterbi_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, ACS, FLUSH, TB, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            stage           <= '0;
            bus.in_ready    <= 1'b0;
            bus.bmu_rx_data <= '0;
            bus.pm_clear    <= 1'b0;
            bus.acs_en      <= 1'b0;
            bus.sp_wr_addr  <= '0;
            bus.tb_en       <= 1'b0;
            bus.tb_addr     <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
        end else begin
            bus.pm_clear <= 1'b0;
            bus.acs_en   <= 1'b0;
            bus.tb_en    <= 1'b0;
            bus.done     <= 1'b0;
`ifdef VITERBI_CTRL_ABORT_EN
            if (bus.abort && state != IDLE) begin
                state        <= IDLE;
                stage        <= '0;
                bus.in_ready <= 1'b0;
                bus.tb_addr  <= '0;
                bus.busy     <= 1'b0;
            end else
`endif
            case (state)
                IDLE: if (bus.start) begin
                    state        <= CLEAR;
                    bus.pm_clear <= 1'b1;
                    bus.busy     <= 1'b1;
                end
                CLEAR: begin
                    state        <= ACS;
                    stage        <= '0;
                    bus.in_ready <= 1'b1;
                end
                ACS: if (bus.in_valid && bus.in_ready) begin
                    bus.bmu_rx_data <= bus.in_data;
                    bus.acs_en      <= 1'b1;
                    bus.sp_wr_addr  <= stage;
                    stage           <= stage + CNT_W'(1);
                    if (stage == LAST) begin
                        state        <= FLUSH;
                        bus.in_ready <= 1'b0;
                    end
                end
                FLUSH: begin
                    state       <= TB;
                    bus.tb_en   <= 1'b1;
                    bus.tb_addr <= LAST;
                end
                // The cycle showing tb_addr==0 is the final traceback step.
                TB: if (bus.tb_addr == '0) begin
                    state    <= DONE;
                    bus.done <= 1'b1;
                end else begin
                    bus.tb_en   <= 1'b1;
                    bus.tb_addr <= bus.tb_addr - CNT_W'(1);
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_viterbi_ctrl.sv
// tb_viterbi_ctrl: randomized bench for viterbi_ctrl against a timeline model of a frame.
// Define VITERBI_CTRL_ABORT_EN to also exercise the abort input.
module tb_viterbi_ctrl;
    localparam int L = 4;

    logic clk = 0;
    logic rst_n = 0;
    int checks = 0, fails = 0;

    viterbi_ctrl_if #(.DATA_WIDTH(2), .FRAME_LEN(L)) b();
    viterbi_ctrl #(.DATA_WIDTH(2), .FRAME_LEN(L)) dut (.clk(clk), .rst_n(rst_n), .bus(b));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is a timeline counted from the start-sampling edge (t=1 is the clear cycle).
    bit         m_act = 0, m_hs = 0;
    int         m_t = 0, m_n = 0, m_f = 0;
    logic [1:0] m_data = 0;
    int         m_addr = 0;

    function automatic int tb_j();
        return (m_act && m_n == L) ? m_t - (m_f + 2) : -1;
    endfunction
    function automatic bit e_ready();
        return m_act && m_t >= 2 && m_n < L;
    endfunction
    function automatic bit e_tb_en();
        return tb_j() >= 0 && tb_j() < L;
    endfunction
    function automatic bit e_done();
        return tb_j() == L;
    endfunction

    bit hs_now, dn_now;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_hs = 0; m_t = 0; m_n = 0; m_f = 0; m_data = 0; m_addr = 0;
        end else begin
            hs_now = e_ready() && b.in_valid;
            dn_now = e_done();
`ifdef VITERBI_CTRL_ABORT_EN
            if (b.abort && m_act) begin
                m_act = 0; m_hs = 0;
            end else
`endif
            if (!m_act) begin
                m_hs = 0;
                if (b.start) begin m_act = 1; m_t = 1; m_n = 0; end
            end else if (dn_now) begin
                m_act = 0; m_hs = 0;
            end else begin
                m_hs = hs_now;
                if (hs_now) begin
                    m_data = b.in_data; m_addr = m_n; m_n++;
                    if (m_n == L) m_f = m_t;
                end
                m_t++;
            end
        end
    end

    int cyc = 0, pc_t = 0, dn_t = 0, done_cnt = 0;
    int acs_q[$], tb_q[$], dn_q[$];
    always @(negedge clk) begin
        cyc++;
        chk("busy", int'(b.busy), int'(m_act));
        chk("pm_clear", int'(b.pm_clear), int'(m_act && m_t == 1));
        chk("in_ready", int'(b.in_ready), int'(e_ready()));
        chk("acs_en", int'(b.acs_en), int'(m_hs));
        chk("bmu_rx_data", int'(b.bmu_rx_data), int'(m_data));
        chk("sp_wr_addr", int'(b.sp_wr_addr), m_addr);
        chk("tb_en", int'(b.tb_en), int'(e_tb_en()));
        chk("tb_addr", int'(b.tb_addr), e_tb_en() ? L - 1 - tb_j() : 0);
        chk("done", int'(b.done), int'(e_done()));
        if (b.acs_en) acs_q.push_back(int'(b.bmu_rx_data) * 16 + int'(b.sp_wr_addr));
        if (b.tb_en) tb_q.push_back(int'(b.tb_addr));
        if (b.pm_clear) pc_t = cyc;
        if (b.done) begin dn_t = cyc; dn_q.push_back(cyc); done_cnt++; end
    end

    task automatic run_frame(input int mode, input bit keep, input int want, input bit rst_mid);
        int got0 = done_cnt, c = 0;
        bit fired = 0;
        logic [1:0] syms[4] = '{2'b00, 2'b11, 2'b10, 2'b01};
        bit pat[7] = '{1, 0, 0, 1, 0, 1, 1};
        if (mode == 2) foreach (syms[i]) syms[i] = 2'($urandom);
        acs_q.delete(); tb_q.delete(); dn_q.delete();
        @(posedge clk); #2 b.start = 1; b.in_valid = 0;
        while (done_cnt - got0 < want && c < 200 && !fired) begin
            @(posedge clk); #2 c++;
            b.start = keep;
            b.in_valid = mode == 0 ? 1'b1 : mode == 1 ? pat[c % 7] : ($urandom_range(0, 2) != 0);
            b.in_data = syms[m_n < L ? m_n : 0];
            if (rst_mid && b.tb_en && b.tb_addr == 2) begin
                #1 rst_n = 0;
                #1 chk("rst_busy", int'(b.busy), 0);
                chk("rst_tb_en", int'(b.tb_en), 0);
                chk("rst_tb_addr", int'(b.tb_addr), 0);
                fired = 1;
                repeat (2) @(posedge clk);
                #2 rst_n = 1;
            end
        end
        b.start = 0; b.in_valid = 0;
        if (!fired) chk("frame_timeout", int'(c < 200), 1);
    endtask

    task automatic pin_nominal();
        chk("n_acs_count", acs_q.size(), 4);
        chk("n_acs0", acs_q[0], 0);
        chk("n_acs1", acs_q[1], 49);
        chk("n_acs2", acs_q[2], 34);
        chk("n_acs3", acs_q[3], 19);
        chk("n_tb_count", tb_q.size(), 4);
        chk("n_tb_seq", tb_q[0] * 1000 + tb_q[1] * 100 + tb_q[2] * 10 + tb_q[3], 3210);
        chk("n_clear_to_done", dn_t - pc_t, 10);
    endtask

    initial begin
        b.start = 1; b.in_valid = 0; b.in_data = 0;
`ifdef VITERBI_CTRL_ABORT_EN
        b.abort = 0;
`endif
        repeat (3) @(posedge clk);
        #2 b.start = 0;
        rst_n = 1;
        repeat (3) @(posedge clk);
        chk("idle_after_reset", done_cnt, 0);

        run_frame(0, 0, 1, 0);
        pin_nominal();

        run_frame(1, 0, 1, 0);
        chk("s_acs_count", acs_q.size(), 4);
        chk("s_acs_seq", acs_q[0] * 1000000 + acs_q[1] * 10000 + acs_q[2] * 100 + acs_q[3], 4934 * 100 + 19);

        run_frame(0, 1, 2, 0);
        chk("b2b_dones", dn_q.size(), 2);
        chk("b2b_gap", pc_t - dn_q[0], 2);

        run_frame(0, 0, 1, 1);
        repeat (2) @(posedge clk);
        run_frame(0, 0, 1, 0);
        pin_nominal();

        repeat (20) begin
            run_frame(2, 0, 1, 0);
            chk("r_tb_count", tb_q.size(), 4);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

`ifdef VITERBI_CTRL_ABORT_EN
        begin
            int d0 = done_cnt, c = 0;
            @(posedge clk); #2 b.start = 1; b.in_valid = 1;
            @(posedge clk); #2 b.start = 0;
            while (m_n < 2 && c < 50) begin @(posedge clk); #2 c++; end
            b.abort = 1;
            @(posedge clk); #2 b.abort = 0; b.in_valid = 0;
            chk("ab_busy", int'(b.busy), 0);
            chk("ab_in_ready", int'(b.in_ready), 0);
            repeat (20) @(posedge clk);
            chk("ab_no_done", done_cnt, d0);
        end
        run_frame(0, 0, 1, 0);
        pin_nominal();
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
